// File: rtl/rr_arb_mux_4_1.sv
// Four-channel round-robin arbiter with packet locking feeding a 4:1 data mux.
// The selected beat is captured in a one-entry output register with a valid/ready handshake.
module rr_arb_mux_4_1 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       in_valid,
   input  logic [3:0]       in_last,
   output logic [3:0]       in_ready,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_sel,
   output logic             out_last
);

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       owner_q, owner_d;
   logic [1:0]       ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       out_sel_q, out_sel_d;
   logic             out_last_q, out_last_d;

   logic             found;
   logic [1:0]       winner;
   logic [1:0]       idx;
   logic             load_en;
   logic [1:0]       grant_ch;
   logic             grant_ok;
   logic             xfer;
   logic [WIDTH-1:0] grant_data;

   // Rotating priority scan starting at ptr; the first valid channel wins.
   always_comb begin
      found  = 1'b0;
      winner = ptr_q;
      idx    = '0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && in_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      load_en  = !out_valid_q || out_ready;
      grant_ch = (state_q == LOCK) ? owner_q : winner;
      grant_ok = (state_q == LOCK) || found;
      in_ready = '0;
      if (grant_ok) begin
         in_ready[grant_ch] = load_en;
      end
      xfer = grant_ok && load_en && in_valid[grant_ch];
      unique case (grant_ch)
         2'd0:    grant_data = d0;
         2'd1:    grant_data = d1;
         2'd2:    grant_data = d2;
         default: grant_data = d3;
      endcase
   end

   // The lock owner keeps the grant even while it idles, so packets never interleave.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_last_d  = out_last_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data;
         out_sel_d   = grant_ch;
         out_last_d  = in_last[grant_ch];
         if (in_last[grant_ch]) begin
            state_d = ARB;
            ptr_d   = grant_ch + 2'd1;
         end else begin
            state_d = LOCK;
            owner_d = grant_ch;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB;
         owner_q     <= '0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Self-checking bench for rr_arb_mux_4_1: scenario tasks plus a scoreboard of expected output beats.
module tb_rr_arb_mux_4_1;

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] data;
      logic       last;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_valid, in_last, in_ready;
   logic [3:0] d0, d1, d2, d3;
   logic       out_valid, out_ready, out_last;
   logic [3:0] out_data;
   logic [1:0] out_sel;

   int    checks   = 0;
   int    failures = 0;
   beat_t sb[$];
   beat_t exp_beat;

   always #5 clk = ~clk;

   rr_arb_mux_4_1 #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_last  (out_last)
   );

   // Every beat handed downstream is matched against the oldest expected beat.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_beat: got sel=%0d data=%h last=%b, required no beat",
                     out_sel, out_data, out_last);
         end else begin
            exp_beat = sb.pop_front();
            if ({out_sel, out_data, out_last} !== exp_beat) begin
               failures++;
               $display("[TB] FAIL out_beat: got sel=%0d data=%h last=%b, required sel=%0d data=%h last=%b",
                        out_sel, out_data, out_last, exp_beat.sel, exp_beat.data, exp_beat.last);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   task automatic wait_drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         @(posedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_empty(input string name);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL %s_drain: got %0d beats outstanding, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid  = 4'($urandom);
         in_last   = 4'($urandom);
         d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
         out_ready = 1'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid  = 4'b0000;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid);
      end
      checks++;
      if (out_sel !== 2'd0) begin
         failures++; $display("[TB] FAIL reset_out_sel: got %0d, required 0", out_sel);
      end
      checks++;
      if (out_data !== 4'h0 || out_last !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_out_data: got data=%h last=%b, required 0/0", out_data, out_last);
      end
      checks++;
      if (in_ready !== 4'b0000) begin
         failures++; $display("[TB] FAIL reset_in_ready: got %b, required 0000", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_rotation();
      logic [3:0] exp_rdy;
      logic [3:0] vals [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
      d0 = vals[0]; d1 = vals[1]; d2 = vals[2]; d3 = vals[3];
      in_last   = 4'hF;
      out_ready = 1'b1;
      in_valid  = 4'hF;
      for (int i = 0; i < 5; i++) begin
         sb.push_back('{sel: 2'(i % 4), data: vals[i % 4], last: 1'b1});
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         exp_rdy = 4'b0001 << (i % 4);
         checks++;
         if (in_ready !== exp_rdy) begin
            failures++; $display("[TB] FAIL rotation_in_ready[%0d]: got %b, required %b", i, in_ready, exp_rdy);
         end
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1) begin
               failures++; $display("[TB] FAIL rotation_throughput[%0d]: got out_valid=%b, required 1", i, out_valid);
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 4'b0000;
      wait_drain();
      check_empty("rotation");
   endtask

   task automatic test_backpressure();
      in_valid  = 4'b0001;
      in_last   = 4'b0001;
      d0        = 4'h5;
      out_ready = 1'b0;
      sb.push_back('{sel: 2'd0, data: 4'h5, last: 1'b1});
      sb.push_back('{sel: 2'd0, data: 4'h6, last: 1'b1});
      @(posedge clk);
      #1;
      d0 = 4'h6;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 4'b0000) begin
            failures++; $display("[TB] FAIL bp_in_ready[%0d]: got %b, required 0000", i, in_ready);
         end
         checks++;
         if (out_valid !== 1'b1 || out_data !== 4'h5) begin
            failures++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h, required 1/5", i, out_valid, out_data);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0001) begin
         failures++; $display("[TB] FAIL bp_release_ready: got %b, required 0001", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 4'b0000;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'h6) begin
         failures++; $display("[TB] FAIL bp_no_bubble: got valid=%b data=%h, required 1/6", out_valid, out_data);
      end
      wait_drain();
      check_empty("backpressure");
   endtask

   task automatic test_packet_lock();
      logic [3:0] exp_rdy [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001};
      d0 = 4'h8;
      d2 = 4'h9;
      out_ready = 1'b1;
      in_valid  = 4'b0111;
      sb.push_back('{sel: 2'd1, data: 4'h1, last: 1'b0});
      sb.push_back('{sel: 2'd1, data: 4'h2, last: 1'b0});
      sb.push_back('{sel: 2'd1, data: 4'h3, last: 1'b1});
      sb.push_back('{sel: 2'd2, data: 4'h9, last: 1'b1});
      sb.push_back('{sel: 2'd0, data: 4'h8, last: 1'b1});
      for (int b = 0; b < 5; b++) begin
         if (b < 3) begin
            d1      = 4'(b + 1);
            in_last = (b == 2) ? 4'b0111 : 4'b0101;
         end else begin
            in_valid = 4'b0101;
            in_last  = 4'b0101;
         end
         @(negedge clk);
         checks++;
         if (in_ready !== exp_rdy[b]) begin
            failures++; $display("[TB] FAIL lock_in_ready[%0d]: got %b, required %b", b, in_ready, exp_rdy[b]);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 4'b0000;
      wait_drain();
      check_empty("packet_lock");
   endtask

   task automatic test_owner_stall();
      out_ready = 1'b1;
      in_valid  = 4'b1010;
      in_last   = 4'b1000;
      d1 = 4'h1;
      d3 = 4'h7;
      sb.push_back('{sel: 2'd1, data: 4'h1, last: 1'b0});
      sb.push_back('{sel: 2'd1, data: 4'h2, last: 1'b1});
      sb.push_back('{sel: 2'd3, data: 4'h7, last: 1'b1});
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0010) begin
         failures++; $display("[TB] FAIL stall_first_ready: got %b, required 0010", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 4'b1000;
      for (int g = 0; g < 2; g++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 4'b0010) begin
            failures++; $display("[TB] FAIL stall_gap_ready[%0d]: got %b, required 0010", g, in_ready);
         end
         if (g == 1) begin
            checks++;
            if (out_valid !== 1'b0) begin
               failures++; $display("[TB] FAIL stall_gap_idle: got out_valid=%b, required 0", out_valid);
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 4'b1010;
      in_last  = 4'b1010;
      d1 = 4'h2;
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0010) begin
         failures++; $display("[TB] FAIL stall_last_ready: got %b, required 0010", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 4'b1000;
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b1000) begin
         failures++; $display("[TB] FAIL stall_after_ready: got %b, required 1000", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 4'b0000;
      wait_drain();
      check_empty("owner_stall");
   endtask

   task automatic test_reset_mid_packet();
      in_valid  = 4'b0100;
      in_last   = 4'b0000;
      d2        = 4'h3;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2) begin
         failures++; $display("[TB] FAIL midrst_loaded: got valid=%b sel=%0d, required 1/2", out_valid, out_sel);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL midrst_async_clear: got out_valid=%b, required 0", out_valid);
      end
      in_valid  = 4'hF;
      in_last   = 4'hF;
      d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.push_back('{sel: 2'd0, data: 4'hA, last: 1'b1});
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0001) begin
         failures++; $display("[TB] FAIL midrst_restart_ready: got %b, required 0001", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 4'b0000;
      wait_drain();
      check_empty("reset_mid_packet");
   endtask

   initial begin
      in_valid  = '0;
      in_last   = '0;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      test_reset();
      test_rotation();
      test_backpressure();
      test_packet_lock();
      test_owner_stall();
      test_reset_mid_packet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
